// File: rtl/contador_mod_n.sv
// contador_mod_n: a modulo-MODULUS up/down counter with preset and load.
// It also keeps a saturating count of wrap events.
// The terminal output is a combinational cascade carry. Driving the enable
// of the next digit with it builds a synchronous multi-digit counter.
`timescale 1ns/1ps

module contador_mod_n #(
    parameter int WIDTH      = 4,
    parameter int MODULUS    = 13,
    parameter int WRAP_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  preset,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_value,
    input  logic                  enable,
    input  logic                  up_down,
    output logic [WIDTH-1:0]      counter,
    output logic                  terminal,
    output logic                  load_error,
    output logic [WRAP_WIDTH-1:0] wraps
);

    // Refuse to build with a modulus that the count register cannot hold.
    generate
        if (MODULUS < 2 || MODULUS > (2 ** WIDTH) || WRAP_WIDTH < 1) begin : g_bad_params
            $error("contador_mod_n: need 2 <= MODULUS <= 2**WIDTH and WRAP_WIDTH >= 1");
        end
    endgenerate

    // The highest legal count. This is also the preset target.
    localparam logic [WIDTH-1:0] LAST_COUNT = WIDTH'(MODULUS - 1);

    // The modulus is widened by one bit so that MODULUS == 2**WIDTH still compares correctly.
    localparam logic [WIDTH:0] MODULUS_EXT = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] next_count;
    logic             load_in_range;

    // This block computes the next enabled count, the terminal carry and the load range check.
    always_comb begin
        next_count    = counter;
        terminal      = 1'b0;
        load_in_range = ({1'b0, load_value} < MODULUS_EXT);
        if (up_down) begin
            terminal   = enable && (counter == LAST_COUNT);
            next_count = (counter == LAST_COUNT) ? '0 : counter + WIDTH'(1);
        end else begin
            terminal   = enable && (counter == '0);
            next_count = (counter == '0) ? LAST_COUNT : counter - WIDTH'(1);
        end
    end

    // This block is the state register. Priority is reset, then preset, then load, then enable.
    // A wrap is counted only when the enabled step is not overridden.
    always_ff @(posedge clock) begin
        if (reset) begin
            counter    <= '0;
            wraps      <= '0;
            load_error <= 1'b0;
        end else if (preset) begin
            counter    <= LAST_COUNT;
            load_error <= 1'b0;
        end else if (load) begin
            if (load_in_range) begin
                counter    <= load_value;
                load_error <= 1'b0;
            end else begin
                counter    <= LAST_COUNT;
                load_error <= 1'b1;
            end
        end else begin
            load_error <= 1'b0;
            if (enable) begin
                counter <= next_count;
            end
            if (terminal && (wraps != '1)) begin
                wraps <= wraps + WRAP_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_contador_mod_n.sv
// Testbench for contador_mod_n.
// The main instance uses the default parameters and is checked through a
// scoreboard that a modular-arithmetic model fills.
// A small instance (MODULUS=2, WRAP_WIDTH=2) exercises wrap saturation.
// Two MODULUS=10 stages exercise cascading.
`timescale 1ns/1ps

module tb_contador_mod_n;

    localparam int MOD      = 13;
    localparam int WRAP_MAX = 255;

    typedef struct {
        int term;
        int cnt;
        int err;
        int wraps;
    } exp_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int num_checks = 0;
    int num_fail   = 0;

    exp_t sb_q[$];

    int m_cnt   = 0;
    int m_wraps = 0;
    int m_err   = 0;

    // Main instance with the default parameters.
    logic       reset, preset, load, enable, up_down;
    logic [3:0] load_value;
    logic [3:0] counter;
    logic       terminal, load_error;
    logic [7:0] wraps;

    contador_mod_n dut (
        .clock(clock), .reset(reset), .preset(preset), .load(load),
        .load_value(load_value), .enable(enable), .up_down(up_down),
        .counter(counter), .terminal(terminal), .load_error(load_error),
        .wraps(wraps)
    );

    // Saturation instance.
    logic       s_reset, s_enable;
    logic [0:0] s_counter;
    logic       s_terminal, s_load_error;
    logic [1:0] s_wraps;

    contador_mod_n #(.WIDTH(1), .MODULUS(2), .WRAP_WIDTH(2)) dut_sat (
        .clock(clock), .reset(s_reset), .preset(1'b0), .load(1'b0),
        .load_value(1'b0), .enable(s_enable), .up_down(1'b1),
        .counter(s_counter), .terminal(s_terminal), .load_error(s_load_error),
        .wraps(s_wraps)
    );

    // Two cascaded decimal digits.
    logic       c_reset, c_enable;
    logic [3:0] lo_counter, hi_counter;
    logic       lo_terminal, hi_terminal, lo_err, hi_err;
    logic [7:0] lo_wraps, hi_wraps;

    contador_mod_n #(.WIDTH(4), .MODULUS(10), .WRAP_WIDTH(8)) dut_lo (
        .clock(clock), .reset(c_reset), .preset(1'b0), .load(1'b0),
        .load_value(4'd0), .enable(c_enable), .up_down(1'b1),
        .counter(lo_counter), .terminal(lo_terminal), .load_error(lo_err),
        .wraps(lo_wraps)
    );

    contador_mod_n #(.WIDTH(4), .MODULUS(10), .WRAP_WIDTH(8)) dut_hi (
        .clock(clock), .reset(c_reset), .preset(1'b0), .load(1'b0),
        .load_value(4'd0), .enable(lo_terminal), .up_down(1'b1),
        .counter(hi_counter), .terminal(hi_terminal), .load_error(hi_err),
        .wraps(hi_wraps)
    );

    function automatic void checkOutput(input string name, input logic [31:0] actual,
                                        input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endfunction

    // Drive one cycle into the main instance. The model pushes the response it
    // expects: terminal before the edge, and the state after it.
    task automatic applyStimulus(input logic r, input logic p, input logic l,
                                 input logic [3:0] lv, input logic e, input logic ud);
        exp_t x;
        int   old;
        bit   wrapped;
        reset      = r;
        preset     = p;
        load       = l;
        load_value = lv;
        enable     = e;
        up_down    = ud;
        old        = m_cnt;
        wrapped    = 1'b0;
        x.term = (e && ((ud && old == MOD - 1) || (!ud && old == 0))) ? 1 : 0;
        if (r) begin
            m_cnt = 0; m_wraps = 0; m_err = 0;
        end else if (p) begin
            m_cnt = MOD - 1; m_err = 0;
        end else if (l) begin
            if (int'(lv) < MOD) begin
                m_cnt = int'(lv); m_err = 0;
            end else begin
                m_cnt = MOD - 1; m_err = 1;
            end
        end else begin
            m_err = 0;
            if (e) begin
                if (ud) begin
                    m_cnt   = (old + 1) % MOD;
                    wrapped = (old + 1 == MOD);
                end else begin
                    m_cnt   = (old + MOD - 1) % MOD;
                    wrapped = (old == 0);
                end
                if (wrapped) m_wraps = (m_wraps >= WRAP_MAX) ? WRAP_MAX : m_wraps + 1;
            end
        end
        x.cnt   = m_cnt;
        x.err   = m_err;
        x.wraps = m_wraps;
        sb_q.push_back(x);
        @(negedge clock);
    endtask

    // Monitor: check terminal mid-cycle, then check the registered outputs just after the edge.
    initial begin
        exp_t x;
        forever begin
            @(negedge clock);
            #3;
            if (sb_q.size() > 0) begin
                x = sb_q[0];
                checkOutput("terminal", 32'(terminal), x.term);
                @(posedge clock);
                #1;
                x = sb_q.pop_front();
                checkOutput("counter", 32'(counter), x.cnt);
                checkOutput("load_error", 32'(load_error), x.err);
                checkOutput("wraps", 32'(wraps), x.wraps);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation timed out");
    end

    initial begin
        reset = 1'b1; preset = 1'b0; load = 1'b0; load_value = 4'd0;
        enable = 1'b0; up_down = 1'b1;
        s_reset = 1'b1; s_enable = 1'b0;
        c_reset = 1'b1; c_enable = 1'b0;
        @(negedge clock);
        @(negedge clock);

        $display("[TB] count up through a wrap");
        applyStimulus(1, 0, 0, 4'd0, 0, 1);
        repeat (14) applyStimulus(0, 0, 0, 4'd0, 1, 1);

        $display("[TB] count down from zero");
        applyStimulus(1, 0, 0, 4'd0, 0, 1);
        repeat (3) applyStimulus(0, 0, 0, 4'd0, 1, 0);

        $display("[TB] out-of-range and legal loads");
        applyStimulus(0, 0, 1, 4'd15, 0, 1);
        applyStimulus(0, 0, 1, 4'd5, 0, 1);
        applyStimulus(0, 0, 0, 4'd0, 0, 1);

        $display("[TB] priority of reset, preset and load");
        applyStimulus(0, 0, 1, 4'd7, 0, 1);
        applyStimulus(1, 1, 1, 4'd7, 1, 1);
        applyStimulus(0, 1, 1, 4'd3, 0, 1);
        applyStimulus(0, 1, 0, 4'd0, 1, 1);
        applyStimulus(0, 0, 1, 4'd0, 0, 1);
        applyStimulus(0, 0, 1, 4'd4, 1, 0);
        applyStimulus(0, 0, 1, 4'd13, 0, 0);
        applyStimulus(0, 0, 0, 4'd0, 1, 1);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 39) == 0),
                          ($urandom_range(0, 19) == 0),
                          ($urandom_range(0, 9) == 0),
                          4'($urandom_range(0, 15)),
                          ($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 1)));
        end

        begin
            int k = 0;
            while (sb_q.size() != 0 && k < 10) begin
                @(posedge clock);
                k++;
            end
            if (sb_q.size() != 0) checkOutput("scoreboard_drain", 32'(sb_q.size()), 0);
        end
        reset = 1'b0; preset = 1'b0; load = 1'b0; enable = 1'b0;

        $display("[TB] wrap counter saturation");
        @(negedge clock);
        checkOutput("sat_reset_counter", 32'(s_counter), 0);
        checkOutput("sat_reset_wraps", 32'(s_wraps), 0);
        s_reset  = 1'b0;
        s_enable = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            #1;
            checkOutput("sat_terminal", 32'(s_terminal), ((n - 1) % 2 == 1) ? 1 : 0);
            @(posedge clock);
            #1;
            checkOutput("sat_counter", 32'(s_counter), n % 2);
            checkOutput("sat_wraps", 32'(s_wraps), (n / 2 > 3) ? 3 : n / 2);
            @(negedge clock);
        end
        s_enable = 1'b0;

        $display("[TB] two-digit cascade");
        checkOutput("casc_reset_lo", 32'(lo_counter), 0);
        checkOutput("casc_reset_hi", 32'(hi_counter), 0);
        c_reset  = 1'b0;
        c_enable = 1'b1;
        for (int n = 1; n <= 105; n++) begin
            @(posedge clock);
            #1;
            checkOutput("casc_lo_digit", 32'(lo_counter), n % 10);
            checkOutput("casc_hi_digit", 32'(hi_counter), (n / 10) % 10);
            checkOutput("casc_lo_wraps", 32'(lo_wraps), n / 10);
            checkOutput("casc_hi_wraps", 32'(hi_wraps), n / 100);
            @(negedge clock);
        end
        c_enable = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
        $finish;
    end

endmodule

// File: doc/contador_mod_n.md
CONTADOR_MOD_N -- requirements
Module: contador_mod_n

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 4, bit width of the count register.
REQ-002 The block SHALL provide parameter MODULUS, default 13, number of count states (0..MODULUS-1).
REQ-003 The block SHALL provide parameter WRAP_WIDTH, default 8, bit width of the wrap-event counter.
REQ-004 The block SHALL fail elaboration unless 2 <= MODULUS <= 2**WIDTH and WRAP_WIDTH >= 1.
REQ-005 clock  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high; highest priority.
REQ-007 preset  input  1  synchronous; forces count to MODULUS-1.
REQ-008 load  input  1  synchronous; loads load_value.
REQ-009 load_value  input  WIDTH  value to load.
REQ-010 enable  input  1  count enable (cascade input).
REQ-011 up_down  input  1  1 = count up, 0 = count down.
REQ-012 counter  output  WIDTH  registered count value.
REQ-013 terminal  output  1  combinational terminal-count / cascade carry.
REQ-014 load_error  output  1  registered one-cycle flag for an out-of-range load.
REQ-015 wraps  output  WRAP_WIDTH  registered count of wrap events, saturating.

Function
REQ-016 Per-edge priority SHALL be: reset > preset > load > enable > hold.
REQ-017 Preset SHALL set counter to MODULUS-1 without changing wraps.
REQ-018 Load with load_value < MODULUS SHALL set counter to load_value.
REQ-019 Load with load_value >= MODULUS SHALL set counter to MODULUS-1 and assert load_error for the next cycle only.
REQ-020 load_error SHALL be 0 in every cycle not following an out-of-range load, including after reset or preset.
REQ-021 With enable=1 and up_down=1, counter SHALL go to counter+1, or to 0 when counter == MODULUS-1.
REQ-022 With enable=1 and up_down=0, counter SHALL go to counter-1, or to MODULUS-1 when counter == 0.
REQ-023 With enable=0 and no reset, preset, or load, counter SHALL hold.
REQ-024 terminal SHALL equal enable AND ((up_down AND counter==MODULUS-1) OR (NOT up_down AND counter==0)).
REQ-025 terminal SHALL be 1 exactly in the cycle whose edge produces a wrap, if that edge is not overridden by reset, preset, or load.
REQ-026 wraps SHALL increment by 1 on each edge where a wrap occurs (REQ-021/022 wrap branch), in either direction.
REQ-027 wraps SHALL saturate at all-ones and SHALL not roll over.
REQ-028 Preset or load coinciding with terminal=1 SHALL take priority; no wrap SHALL be counted on that edge.
REQ-029 Changing up_down SHALL take effect on the next edge with no extra latency or lost count.
REQ-030 counter SHALL never hold a value >= MODULUS after any edge.
REQ-031 Chaining terminal of stage k into enable of stage k+1 (shared clock) SHALL form a synchronous multi-digit counter with no added latency.

Reset
REQ-032 reset=1 at an edge SHALL set counter=0, wraps=0, load_error=0, regardless of other inputs.
REQ-033 During reset, terminal SHALL follow REQ-024 from the held counter value (0 after the first reset edge).
REQ-034 Reset asserted mid-count SHALL take effect on the next edge; no partial or pending state SHALL persist.

Verification
REQ-035 Defaults; reset, then enable=1, up_down=1 for 14 edges -> counter 0,1..12,0,1; terminal high only at 12; wraps=1.
REQ-036 Defaults; up_down=0 from 0 for 3 edges -> counter 12,11,10; terminal high in the first cycle only; wraps=1.
REQ-037 load=1, load_value=15 -> counter=12, load_error=1 for one cycle; load_value=5 -> counter=5, load_error=0.
REQ-038 reset=1, preset=1, load=1 on the same edge, counter=7 -> counter=0, wraps=0; preset+load only -> counter=12.
REQ-039 WRAP_WIDTH=2, MODULUS=2, 12 enabled up edges -> wraps sequence saturates at 3 and holds.
REQ-040 Two MODULUS=10 stages cascaded, 105 enabled edges from reset -> low digit=5, high digit=0, high-stage wraps=1.
